// File: rtl/mips_run_controller.sv
// Drives the mips core's active-high reset through repeated hold/run phases.
// While the core runs, it tracks the maximum PC, the last PC and PC stalls.
module mips_run_controller #(
    parameter int PC_WIDTH    = 16,
    parameter int HOLD_CYCLES = 99,
    parameter int RUN_CYCLES  = 100,
    parameter int ITERATIONS  = 2,
    parameter int STALL_LIMIT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_continuous,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_cpu_reset,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_stall,
    output logic [7:0]          o_run_count,
    output logic [PC_WIDTH-1:0] o_last_pc,
    output logic [PC_WIDTH-1:0] o_max_pc
);
    localparam int PHASE_MAX = (HOLD_CYCLES > RUN_CYCLES) ? HOLD_CYCLES : RUN_CYCLES;
    localparam int CW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int IW = $clog2(ITERATIONS + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_phase_cnt;
    logic [IW-1:0]       r_iter;
    logic [SW-1:0]       r_stall_cnt;
    logic [PC_WIDTH-1:0] r_prev_pc;
    logic                r_first_run;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_stall;
    logic [7:0]          r_run_count;
    logic [PC_WIDTH-1:0] r_last_pc;
    logic [PC_WIDTH-1:0] r_max_pc;

    logic                w_stall_hit;
    logic                w_run_last;
    logic [IW-1:0]       w_iter_inc;
    logic                w_launch;
    logic                w_enter_hold;
    logic                w_enter_run;

    // The first RUN cycle only primes the previous-PC register, so it never counts as a repeat.
    assign w_stall_hit = (r_state == S_RUN) && !r_first_run && (i_pc == r_prev_pc) &&
                         (r_stall_cnt == SW'(STALL_LIMIT - 1));
    assign w_run_last  = (r_state == S_RUN) && ((r_phase_cnt == '0) || w_stall_hit);
    // Saturates so continuous mode cannot wrap the iteration count.
    assign w_iter_inc  = (r_iter == IW'(ITERATIONS)) ? r_iter : r_iter + IW'(1);
    assign w_launch    = !i_abort && i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_enter_hold = (w_state_next == S_HOLD) && (r_state != S_HOLD);
    assign w_enter_run  = (w_state_next == S_RUN) && (r_state != S_RUN);

    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (i_start) w_state_next = S_HOLD;
                S_HOLD:         if (r_phase_cnt == '0) w_state_next = S_RUN;
                S_RUN: begin
                    if (w_run_last)
                        w_state_next = (i_continuous || (w_iter_inc < IW'(ITERATIONS))) ? S_HOLD : S_DONE;
                end
                default:        w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stall     <= 1'b0;
            r_run_count <= '0;
            r_last_pc   <= '0;
            r_max_pc    <= '0;
            r_phase_cnt <= '0;
            r_iter      <= '0;
            r_stall_cnt <= '0;
            r_prev_pc   <= '0;
            r_first_run <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_reset <= (w_state_next != S_RUN);
            r_busy      <= (w_state_next == S_HOLD) || (w_state_next == S_RUN);
            r_done      <= (w_state_next == S_DONE);
            r_first_run <= w_enter_run;

            if (w_enter_hold)
                r_phase_cnt <= CW'(HOLD_CYCLES - 1);
            else if (w_enter_run)
                r_phase_cnt <= CW'(RUN_CYCLES - 1);
            else if (r_phase_cnt != '0)
                r_phase_cnt <= r_phase_cnt - CW'(1);

            if (w_launch) begin
                r_stall     <= 1'b0;
                r_run_count <= '0;
                r_last_pc   <= '0;
                r_max_pc    <= '0;
                r_iter      <= '0;
                r_stall_cnt <= '0;
            end else if ((r_state == S_RUN) && !i_abort) begin
                r_prev_pc <= i_pc;
                if (i_pc > r_max_pc)
                    r_max_pc <= i_pc;
                if (r_first_run || (i_pc != r_prev_pc))
                    r_stall_cnt <= '0;
                else
                    r_stall_cnt <= r_stall_cnt + SW'(1);
                if (w_stall_hit)
                    r_stall <= 1'b1;
                if (w_run_last) begin
                    r_last_pc <= i_pc;
                    r_iter    <= w_iter_inc;
                    if (r_run_count != 8'hFF)
                        r_run_count <= r_run_count + 8'd1;
                end
            end
        end
    end

    assign o_cpu_reset = r_cpu_reset;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_stall     = r_stall;
    assign o_run_count = r_run_count;
    assign o_last_pc   = r_last_pc;
    assign o_max_pc    = r_max_pc;
endmodule
